div_ratio_ctrl: RTL and testbench

DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

---
 rtl/div_ratio_ctrl.sv | 108 ++++++++++
 tb/tb_div_ratio_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/div_ratio_ctrl.sv
// Clock-divider ratio controller: gates the divider clock-enable off, drains the
// old period, loads the new ratio and resumes, with a valid/ready config port.
module div_ratio_ctrl #(
    parameter int                  RATIO_WD      = 8,
    parameter logic [RATIO_WD-1:0] DEFAULT_RATIO = 8'd2
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_cfg_valid,
    input  logic [RATIO_WD-1:0] i_cfg_ratio,
    output logic                o_cfg_ready,
    output logic                o_clk_en,
    output logic [RATIO_WD-1:0] o_div_ratio,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LOAD,
        RESUME
    } state_t;

    localparam logic [RATIO_WD-1:0] ONE = RATIO_WD'(1);

    state_t              state_q, state_d;
    logic [RATIO_WD-1:0] cnt_q, cnt_d;
    logic [RATIO_WD-1:0] pend_q, pend_d;
    logic [RATIO_WD-1:0] ratio_d;
    logic                clk_en_d, done_d, err_d;
    logic                handshake;

    assign handshake = i_cfg_valid & o_cfg_ready;

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        ratio_d  = o_div_ratio;
        clk_en_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                clk_en_d = i_en;
                if (handshake) begin
                    if (i_cfg_ratio == '0) begin
                        err_d = 1'b1;
                    end else if (i_cfg_ratio == o_div_ratio) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d   = i_cfg_ratio;
                        // A zero ratio can only come from DEFAULT_RATIO; drain at least once.
                        cnt_d    = (o_div_ratio == '0) ? ONE : o_div_ratio;
                        clk_en_d = 1'b0;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q <= ONE) state_d = LOAD;
                else              cnt_d   = cnt_q - ONE;
            end
            LOAD: begin
                ratio_d = pend_q;
                state_d = RESUME;
            end
            RESUME: begin
                clk_en_d = i_en;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            o_div_ratio <= DEFAULT_RATIO;
            o_clk_en    <= 1'b0;
            o_done      <= 1'b0;
            o_cfg_err   <= 1'b0;
            o_busy      <= 1'b0;
            o_cfg_ready <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            o_div_ratio <= ratio_d;
            o_clk_en    <= clk_en_d;
            o_done      <= done_d;
            o_cfg_err   <= err_d;
            o_busy      <= (state_d != IDLE);
            o_cfg_ready <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Self-checking bench for div_ratio_ctrl: a scoreboard of expected done/err
// completions plus cycle-by-cycle checks of the enable gating and ratio load.
module tb_div_ratio_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_ratio;
    logic         cfg_ready;
    logic         clk_en;
    logic [W-1:0] div_ratio;
    logic         busy;
    logic         done;
    logic         cfg_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit           is_err;
        logic [W-1:0] ratio;
        int           due;
    } exp_t;

    exp_t sb[$];

    div_ratio_ctrl #(.RATIO_WD(W), .DEFAULT_RATIO(8'd2)) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_cfg_valid (cfg_valid),
        .i_cfg_ratio (cfg_ratio),
        .o_cfg_ready (cfg_ready),
        .o_clk_en    (clk_en),
        .o_div_ratio (div_ratio),
        .o_busy      (busy),
        .o_done      (done),
        .o_cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every done/err pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && (done || cfg_err)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pulse", {30'd0, done, cfg_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_err",     cfg_err,   e.is_err);
                check("sb_done",    done,      !e.is_err);
                check("sb_ratio",   div_ratio, e.ratio);
                check("sb_latency", cyc,       e.due);
            end
        end
    end

    // Requests resolved in IDLE: reject (ratio 0) or same-ratio accept.
    task automatic send_idle(input logic [W-1:0] r, input bit is_err, input logic [W-1:0] cur);
        cfg_valid = 1'b1;
        cfg_ratio = r;
        sb.push_back('{is_err: is_err, ratio: cur, due: cyc + 1});
        tick();
        cfg_valid = 1'b0;
    endtask

    // Full ratio change; i_en is scrambled while the enable must stay gated.
    task automatic change(input int old_r, input logic [W-1:0] new_r, input bit inject);
        int drain;
        drain     = (old_r == 0) ? 1 : old_r;
        cfg_valid = 1'b1;
        cfg_ratio = new_r;
        sb.push_back('{is_err: 1'b0, ratio: new_r, due: cyc + 1 + drain + 2});
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k <= drain + 1; k++) begin
            check("chg_clk_en_gated", clk_en, 1'b0);
            check("chg_busy",         busy,   1'b1);
            check("chg_ready_low",    cfg_ready, 1'b0);
            check("chg_ratio",        div_ratio, (k == drain + 1) ? new_r : W'(old_r));
            cfg_valid = inject && (k == 0);
            cfg_ratio = inject && (k == 0) ? 8'd7 : new_r;
            en        = (k == drain + 1) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            cfg_valid = 1'b0;
        end
        check("chg_clk_en_resumed", clk_en,    1'b1);
        check("chg_busy_clear",     busy,      1'b0);
        check("chg_ready_back",     cfg_ready, 1'b1);
        check("chg_final_ratio",    div_ratio, new_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ratio = '0;
        tick(2);
        check("rst_ratio",  div_ratio, 8'd2);
        check("rst_clk_en", clk_en,    1'b0);
        check("rst_busy",   busy,      1'b0);
        check("rst_done",   done,      1'b0);
        check("rst_err",    cfg_err,   1'b0);

        rst = 1'b0;
        tick();
        check("post_rst_ready",  cfg_ready, 1'b1);
        check("post_rst_clk_en", clk_en,    1'b0);
        en = 1'b1;
        tick();
        check("en_clk_en", clk_en,    1'b1);
        check("en_busy",   busy,      1'b0);
        check("en_ratio",  div_ratio, 8'd2);

        send_idle(8'd0, 1'b1, 8'd2);
        check("rej_ratio",  div_ratio, 8'd2);
        check("rej_clk_en", clk_en,    1'b1);
        check("rej_busy",   busy,      1'b0);
        tick();
        check("rej_err_one_cycle", cfg_err, 1'b0);

        send_idle(8'd2, 1'b0, 8'd2);
        for (int i = 0; i < 3; i++) begin
            check("same_clk_en", clk_en, 1'b1);
            check("same_busy",   busy,   1'b0);
            tick();
        end

        change(2, 8'd5, 1'b0);
        change(5, 8'd3, 1'b1);

        en = 1'b0;
        tick();
        check("idle_follow_en_low", clk_en, 1'b0);
        en = 1'b1;
        tick();
        check("idle_follow_en_high", clk_en, 1'b1);

        change(3, 8'd255, 1'b0);
        change(255, 8'd1, 1'b0);

        cfg_valid = 1'b1;
        cfg_ratio = 8'd8;
        tick();
        cfg_valid = 1'b0;
        check("abort_in_drain", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_ratio",  div_ratio, 8'd2);
        check("abort_clk_en", clk_en,    1'b0);
        check("abort_busy",   busy,      1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_ratio_after",  div_ratio, 8'd2);
        check("abort_ready_after",  cfg_ready, 1'b1);
        check("abort_clk_en_after", clk_en,    1'b1);
        change(2, 8'd4, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
